// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_scoreboard
//  Purpose  : Parametrised register file with two combinational read ports,
//             one write port, an optional hardwired zero register, optional
//             write-to-read bypass and a per-register busy scoreboard with a
//             reserve/release handshake for RAW/WAW hazard stalls.
//  Ports    : clk_i/rst_ni          clock, asynchronous active-low reset
//             aa_i/ab_i             read addresses A/B
//             a_o/b_o               read data A/B
//             a_busy_o/b_busy_o     pending-write flag of the addressed reg
//             wren_i/aw_i/wrdata_i  write port (a write also releases busy)
//             rsv_valid_i/rsv_addr_i/rsv_ready_o  reservation handshake
//             flush_i               clear every busy bit
//             busy_cnt_o            number of busy registers (registered)
//  Revision : 1.0  initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] aa_i,
    input  logic [ADDR_W-1:0] ab_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic              a_busy_o,
    output logic              b_busy_o,
    input  logic              wren_i,
    input  logic [ADDR_W-1:0] aw_i,
    input  logic [DATA_W-1:0] wrdata_i,
    input  logic              rsv_valid_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    output logic              rsv_ready_o,
    input  logic              flush_i,
    output logic [ADDR_W:0]   busy_cnt_o
);

    localparam int c_DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]  r_regs [c_DEPTH];
    logic [c_DEPTH-1:0] r_busy;
    logic [c_DEPTH-1:0] w_busy_nxt;
    logic [ADDR_W:0]    r_busy_cnt;
    logic [ADDR_W:0]    w_cnt_nxt;
    logic               w_wr_ok;
    logic               w_rsv_set;
    logic               w_dec;

    // Address 0 is read-only/never-busy when the zero register is enabled.
    function automatic logic f_writable(input logic [ADDR_W-1:0] addr);
        return !((ZERO_REG != 0) && (addr == '0));
    endfunction

    assign w_wr_ok     = wren_i & f_writable(aw_i);
    // No release credit: a register being written this cycle is still busy.
    assign rsv_ready_o = rsv_valid_i & ~r_busy[rsv_addr_i] & ~flush_i;
    // A granted reservation of the zero register is a no-op.
    assign w_rsv_set   = rsv_ready_o & f_writable(rsv_addr_i);
    assign w_dec       = w_wr_ok & r_busy[aw_i];
    assign busy_cnt_o  = r_busy_cnt;

    // Release is applied before set so that a same-address reserve+write
    // leaves the register busy (the newer reservation wins).
    always_comb begin
        w_busy_nxt = r_busy;
        w_cnt_nxt  = r_busy_cnt;
        if (flush_i) begin
            w_busy_nxt = '0;
            w_cnt_nxt  = '0;
        end else begin
            if (w_wr_ok) begin
                w_busy_nxt[aw_i] = 1'b0;
            end
            if (w_rsv_set) begin
                w_busy_nxt[rsv_addr_i] = 1'b1;
            end
            // Set only targets a non-busy reg and release only a busy one,
            // so the count stays within 0 .. DEPTH-ZERO_REG.
            w_cnt_nxt = r_busy_cnt + (ADDR_W+1)'(w_rsv_set) - (ADDR_W+1)'(w_dec);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[aw_i] <= wrdata_i;
        end
    end

    always_comb begin
        a_o      = r_regs[aa_i];
        a_busy_o = r_busy[aa_i];
        if (!f_writable(aa_i)) begin
            a_o      = '0;
            a_busy_o = 1'b0;
        end else if ((BYPASS != 0) && w_wr_ok && (aw_i == aa_i)) begin
            a_o      = wrdata_i;
            a_busy_o = 1'b0;
        end
    end

    always_comb begin
        b_o      = r_regs[ab_i];
        b_busy_o = r_busy[ab_i];
        if (!f_writable(ab_i)) begin
            b_o      = '0;
            b_busy_o = 1'b0;
        end else if ((BYPASS != 0) && w_wr_ok && (aw_i == ab_i)) begin
            b_o      = wrdata_i;
            b_busy_o = 1'b0;
        end
    end

endmodule
`default_nettype wire
